ipram_boot_loader: RTL and testbench

IPRAM_BOOT_LOADER -- requirements
Module: ipram_boot_loader

---
 rtl/ipram_boot_loader.sv | 207 ++++++++++++++++++++
 tb/tb_ipram_boot_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipram_boot_loader.sv
// ipram_boot_loader
// Copies an image from SPI flash into a byte-wide RAM after a start pulse.
// Issues a READ (0x03) command with a 24-bit address, then streams
// NUM_BYTES data bytes out on wr_en/wr_addr/wr_data.
// SPI runs in mode 0 with an SCK half-period of CLK_DIV clk cycles.
// Optional feature macro: IPRAM_BOOT_LOADER_CHECKSUM_EN.
//   defined   : one extra trailing byte is read, and csum_ok reports whether
//               (sum of data bytes + that byte) mod 256 == 0.
//   undefined : csum_ok simply follows done.
module ipram_boot_loader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int unsigned NUM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        csum_ok
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Command byte followed by the start address, shifted out MSB first
  localparam logic [31:0] HDR_WORD = {8'h03, BASE_ADDR};
  // Last count of an SCK half-period
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  // Byte index value reached once the final image byte has been written
  localparam logic [12:0] END_IDX  = 13'(NUM_BYTES);

  state_t      state_r;
  logic [7:0]  div_cnt_r;    // cycles spent in the current SCK half-period
  logic [4:0]  bit_cnt_r;    // header bit 0..31, or data bit 0..7
  logic [30:0] shift_out_r;  // header bits still to be presented on MOSI
  logic [6:0]  shift_in_r;   // first 7 bits of the byte being received
  logic [12:0] byte_idx_r;   // 13 bits so that 4096 is reachable without wrap
  logic        tail_r;       // final SCK low phase before DONE
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  sum_r;        // running modulo-256 sum of data bytes
  logic        csum_res_r;   // checksum verdict captured on the last bit
`endif

  logic        phase_end_s;
  logic [7:0]  byte_s;

  // Half-period terminal count and the byte as it looks with the current MISO bit
  always_comb begin
    phase_end_s = (div_cnt_r == DIV_LAST);
    byte_s      = {shift_in_r, spi_miso};
  end

  // Load sequencer: SCK generation, header shift-out, data shift-in, RAM writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      spi_cs_n    <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 12'd0;
      wr_data     <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      csum_ok     <= 1'b0;
      div_cnt_r   <= 8'd0;
      bit_cnt_r   <= 5'd0;
      shift_out_r <= 31'd0;
      shift_in_r  <= 7'd0;
      byte_idx_r  <= 13'd0;
      tail_r      <= 1'b0;
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
      sum_r       <= 8'd0;
      csum_res_r  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r     <= ST_CMD;
            spi_cs_n    <= 1'b0;
            spi_sck     <= 1'b0;
            spi_mosi    <= HDR_WORD[31];
            busy        <= 1'b1;
            done        <= 1'b0;
            csum_ok     <= 1'b0;
            div_cnt_r   <= 8'd0;
            bit_cnt_r   <= 5'd0;
            shift_out_r <= HDR_WORD[30:0];
            byte_idx_r  <= 13'd0;
            tail_r      <= 1'b0;
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
            sum_r       <= 8'd0;
`endif
          end
        end

        ST_CMD, ST_ADDR: begin
          if (phase_end_s) begin
            div_cnt_r <= 8'd0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              // Falling edge: the only place MOSI is allowed to move
              spi_sck     <= 1'b0;
              shift_out_r <= {shift_out_r[29:0], 1'b0};
              bit_cnt_r   <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd7) begin
                state_r <= ST_ADDR;
              end
              if (bit_cnt_r == 5'd31) begin
                state_r   <= ST_DATA;
                spi_mosi  <= 1'b0;
                bit_cnt_r <= 5'd0;
              end else begin
                spi_mosi <= shift_out_r[30];
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end

        ST_DATA, ST_CSUM: begin
          if (phase_end_s) begin
            div_cnt_r <= 8'd0;
            if (tail_r) begin
              // Final low phase has elapsed: release the flash
              state_r  <= ST_DONE;
              tail_r   <= 1'b0;
              spi_cs_n <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
              csum_ok  <= csum_res_r;
`else
              csum_ok  <= 1'b1;
`endif
            end else if (!spi_sck) begin
              // Rising edge: sample MISO
              spi_sck    <= 1'b1;
              shift_in_r <= byte_s[6:0];
              if (bit_cnt_r[2:0] == 3'd7) begin
                if (state_r == ST_DATA) begin
                  wr_en      <= 1'b1;
                  wr_data    <= byte_s;
                  wr_addr    <= byte_idx_r[11:0];
                  byte_idx_r <= byte_idx_r + 13'd1;
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
                  sum_r      <= sum_r + byte_s;
                end else begin
                  csum_res_r <= ((sum_r + byte_s) == 8'd0);
`endif
                end
              end
            end else begin
              // Falling edge: advance the bit position
              spi_sck <= 1'b0;
              if (bit_cnt_r[2:0] == 3'd7) begin
                bit_cnt_r <= 5'd0;
                if (state_r == ST_CSUM) begin
                  tail_r <= 1'b1;
                end else if (byte_idx_r == END_IDX) begin
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
                  state_r <= ST_CSUM;
`else
                  tail_r  <= 1'b1;
`endif
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          spi_cs_n <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          csum_ok  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipram_boot_loader.sv
// Bench for ipram_boot_loader: four differently parameterised instances, a
// behavioural mode-0 flash model per instance, and a write scoreboard.
module tb_ipram_boot_loader;

  localparam int NI = 4;
`ifdef IPRAM_BOOT_LOADER_CHECKSUM_EN
  localparam int   CS_EXTRA = 8;
  localparam logic CS_EN    = 1'b1;
`else
  localparam int   CS_EXTRA = 0;
  localparam logic CS_EN    = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start [NI];
  logic csn [NI];
  logic sck [NI];
  logic mosi [NI];
  logic miso [NI];
  logic wen [NI];
  logic busy [NI];
  logic done [NI];
  logic cok [NI];
  logic [11:0] wa [NI];
  logic [7:0]  wd [NI];

  always #5 clk = ~clk;

  ipram_boot_loader #(.CLK_DIV(1), .BASE_ADDR(24'h000000), .NUM_BYTES(4096)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .spi_cs_n(csn[0]), .spi_sck(sck[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .wr_en(wen[0]), .wr_addr(wa[0]),
    .wr_data(wd[0]), .busy(busy[0]), .done(done[0]), .csum_ok(cok[0]));
  ipram_boot_loader #(.CLK_DIV(3), .BASE_ADDR(24'h000000), .NUM_BYTES(16)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .spi_cs_n(csn[1]), .spi_sck(sck[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .wr_en(wen[1]), .wr_addr(wa[1]),
    .wr_data(wd[1]), .busy(busy[1]), .done(done[1]), .csum_ok(cok[1]));
  ipram_boot_loader #(.CLK_DIV(2), .BASE_ADDR(24'h123456), .NUM_BYTES(1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .spi_cs_n(csn[2]), .spi_sck(sck[2]),
    .spi_mosi(mosi[2]), .spi_miso(miso[2]), .wr_en(wen[2]), .wr_addr(wa[2]),
    .wr_data(wd[2]), .busy(busy[2]), .done(done[2]), .csum_ok(cok[2]));
  ipram_boot_loader #(.CLK_DIV(2), .BASE_ADDR(24'h000000), .NUM_BYTES(4)) u3 (
    .clk(clk), .reset(reset), .start(start[3]), .spi_cs_n(csn[3]), .spi_sck(sck[3]),
    .spi_mosi(mosi[3]), .spi_miso(miso[3]), .wr_en(wen[3]), .wr_addr(wa[3]),
    .wr_data(wd[3]), .busy(busy[3]), .done(done[3]), .csum_ok(cok[3]));

  typedef struct {
    int          inst;
    int          nbytes;
    logic [23:0] base;
    logic [7:0]  csb;
    int          restart_at;
    logic [31:0] exp_hdr;
    logic        exp_ok;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [19:0] exp_q [$];
  int          div_tab [NI];
  int          fbit [NI];
  int          rises [NI];
  int          run [NI];
  logic [31:0] hdr [NI];
  logic        psck [NI];
  logic        pmosi [NI];
  logic [11:0] pwa [NI];
  logic [7:0]  pwd [NI];
  logic [7:0]  csb;

  // Flash contents: instance 3 holds a small image plus checksum byte,
  // the others hold byte n = n[7:0] at address n.
  function automatic logic [7:0] fmem(int i, logic [23:0] a);
    if (i == 3) begin
      case (a)
        24'd0:   return 8'h10;
        24'd1:   return 8'h20;
        24'd2:   return 8'h30;
        24'd3:   return 8'h40;
        24'd4:   return csb;
        default: return 8'h00;
      endcase
    end
    return a[7:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clk cycle: sample at the falling clk edge, run the flash models,
  // the write scoreboard and the SCK/MOSI timing monitors.
  task automatic step();
    int k;
    logic [7:0] b;
    logic [19:0] e;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (wen[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL wr_unexpected: inst %0d got addr %0d data %02h, required no write", i, wa[i], wd[i]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("wr_i%0d", i), {wa[i], wd[i]}, {12'd0, e});
        end
      end else if (!reset && (wa[i] !== pwa[i] || wd[i] !== pwd[i])) begin
        n_bad++;
        $display("FAIL wr_hold: inst %0d got %0h/%0h, required %0h/%0h", i, wa[i], wd[i], pwa[i], pwd[i]);
      end
      pwa[i] = wa[i];
      pwd[i] = wd[i];

      if (csn[i] !== 1'b0) begin
        fbit[i] = 0;
        run[i]  = 0;
      end else begin
        if (sck[i] && mosi[i] !== pmosi[i]) begin
          n_bad++;
          $display("FAIL mosi_hi: inst %0d got change to %0b, required no change while sck high", i, mosi[i]);
        end
        if (sck[i] === 1'b1 && psck[i] === 1'b0) begin
          if (fbit[i] < 32) hdr[i] = {hdr[i][30:0], mosi[i]};
          else if (mosi[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL mosi_data: inst %0d got %0b, required 0", i, mosi[i]);
          end
          fbit[i]++;
          rises[i]++;
        end else if (sck[i] === 1'b0 && psck[i] === 1'b1 && fbit[i] >= 32) begin
          k = fbit[i] - 32;
          b = fmem(i, hdr[i][23:0] + 24'(k / 8));
          miso[i] = b[7 - (k % 8)];
        end
        if (sck[i] !== psck[i]) begin
          chk($sformatf("phase_i%0d", i), run[i], div_tab[i]);
          run[i] = 1;
        end else begin
          run[i]++;
        end
      end
      psck[i]  = sck[i];
      pmosi[i] = mosi[i];
    end
  endtask

  task automatic run_load(int i, int nbytes, logic [23:0] base, int restart_at);
    int budget;
    rises[i] = 0;
    hdr[i]   = 32'h0;
    exp_q.delete();
    for (int n = 0; n < nbytes; n++) exp_q.push_back({12'(n), fmem(i, base + 24'(n))});
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    chk("start_busy", busy[i], 1);
    chk("start_csn", csn[i], 0);
    chk("start_done", done[i], 0);
    budget = 2 * div_tab[i] * (48 + 8 * nbytes) + 64;
    while (done[i] !== 1'b1 && budget > 0) begin
      if (restart_at >= 0 && (nbytes - exp_q.size()) == restart_at) begin
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        restart_at = -1;
      end else begin
        step();
      end
      budget--;
    end
    chk("done_in_budget", done[i], 1);
  endtask

  vec_t vt [6];

  initial begin
    int bud;
    vt[0] = '{0, 4096, 24'h000000, 8'h00, 100, 32'h03000000, 1'b1};
    vt[1] = '{1, 16,   24'h000000, 8'h00, -1,  32'h03000000, 1'b1};
    vt[2] = '{2, 1,    24'h123456, 8'h00, -1,  32'h03123456, 1'b1};
    vt[3] = '{3, 4,    24'h000000, 8'h60, -1,  32'h03000000, 1'b1};
    vt[4] = '{3, 4,    24'h000000, 8'hA0, -1,  32'h03000000, !CS_EN};
    vt[5] = '{3, 4,    24'h000000, 8'hA1, -1,  32'h03000000, !CS_EN};
    div_tab[0] = 1; div_tab[1] = 3; div_tab[2] = 2; div_tab[3] = 2;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; miso[i] = 1'b0; fbit[i] = 0; rises[i] = 0; run[i] = 0;
      hdr[i] = 32'h0; psck[i] = 1'b0; pmosi[i] = 1'b0; pwa[i] = 12'd0; pwd[i] = 8'd0;
    end
    csb   = 8'h00;
    reset = 1'b1;
    repeat (3) step();

    // Reset state on every instance
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_csn_i%0d", i), csn[i], 1);
      chk($sformatf("rst_sck_i%0d", i), sck[i], 0);
      chk($sformatf("rst_mosi_i%0d", i), mosi[i], 0);
      chk($sformatf("rst_wen_i%0d", i), wen[i], 0);
      chk($sformatf("rst_wa_i%0d", i), wa[i], 0);
      chk($sformatf("rst_wd_i%0d", i), wd[i], 0);
      chk($sformatf("rst_busy_i%0d", i), busy[i], 0);
      chk($sformatf("rst_done_i%0d", i), done[i], 0);
      chk($sformatf("rst_cok_i%0d", i), cok[i], 0);
    end
    reset = 1'b0;
    repeat (2) step();

    // Table-driven full loads
    for (int v = 0; v < 6; v++) begin
      csb = vt[v].csb;
      run_load(vt[v].inst, vt[v].nbytes, vt[v].base, vt[v].restart_at);
      repeat (3) step();
      chk($sformatf("v%0d_done", v), done[vt[v].inst], 1);
      chk($sformatf("v%0d_busy", v), busy[vt[v].inst], 0);
      chk($sformatf("v%0d_csn", v), csn[vt[v].inst], 1);
      chk($sformatf("v%0d_sck", v), sck[vt[v].inst], 0);
      chk($sformatf("v%0d_csum_ok", v), cok[vt[v].inst], vt[v].exp_ok);
      chk($sformatf("v%0d_rises", v), rises[vt[v].inst],
          32 + 8 * vt[v].nbytes + ((vt[v].inst == 3) ? CS_EXTRA : 0));
      chk($sformatf("v%0d_hdr", v), hdr[vt[v].inst], vt[v].exp_hdr);
      chk($sformatf("v%0d_writes_left", v), exp_q.size(), 0);
    end

    // Reset in the middle of a load, then reload from address 0
    rises[1] = 0;
    hdr[1]   = 32'h0;
    exp_q.delete();
    for (int n = 0; n < 16; n++) exp_q.push_back({12'(n), fmem(1, 24'(n))});
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    bud = 4000;
    while (exp_q.size() > 8 && bud > 0) begin
      step();
      bud--;
    end
    chk("mid_reached", exp_q.size(), 8);
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_csn", csn[1], 1);
    chk("mid_rst_busy", busy[1], 0);
    chk("mid_rst_wen", wen[1], 0);
    chk("mid_rst_sck", sck[1], 0);
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    repeat (200) step();
    chk("mid_idle_csn", csn[1], 1);
    chk("mid_idle_done", done[1], 0);
    run_load(1, 16, 24'h000000, -1);
    repeat (2) step();
    chk("reload_writes_left", exp_q.size(), 0);
    chk("reload_rises", rises[1], 160);
    chk("reload_cok", cok[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
